// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / load-store) arbiter in front
// of a single-port memory with a fixed read latency. Only one transaction is
// in flight at a time; every output is registered.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to arbitrate contention by
// round robin (grant whoever was not granted last). With the macro undefined,
// data requests always win over fetch and no pointer register is built.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic [ADDR_WIDTH-1:0] out_mem_addr,
   output logic [31:0]           out_data,
   output logic                  mem_rd,
   output logic                  mem_wr,
   input  logic [31:0]           in_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   // Wait-counter load value: RD_WAIT lasts RD_LATENCY cycles, counting down to 0.
   localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

   state_t     state_r;
   logic [2:0] wait_cnt_r;
   logic       owner_d_r;   // 1: current transaction belongs to the data port
   logic       write_r;     // 1: current transaction is a store
   logic       ready_r;     // keeps the first edge after reset release issue-free
   logic       pick_d_s;    // arbitration result for this cycle

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic       last_d_r;    // 1: data port was granted last, 0: fetch was
`endif

   // Arbitration: choose which requester would be served if the FSM issues now.
   always_comb begin
      pick_d_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (d_req && if_req) begin
         pick_d_s = ~last_d_r;
      end else if (d_req) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
`else
      if (d_req) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
`endif
   end

   // Transaction FSM with registered strobes, grants, completions and read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         wait_cnt_r   <= 3'd0;
         owner_d_r    <= 1'b0;
         write_r      <= 1'b0;
         ready_r      <= 1'b0;
         if_gnt       <= 1'b0;
         d_gnt        <= 1'b0;
         if_rvalid    <= 1'b0;
         d_rvalid     <= 1'b0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         out_mem_addr <= '0;
         out_data     <= 32'd0;
         if_rdata     <= 32'd0;
         d_rdata      <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_d_r     <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; the cases below raise them for one cycle.
         ready_r   <= 1'b1;
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (ready_r && (if_req || d_req)) begin
                  owner_d_r <= pick_d_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_d_r  <= pick_d_s;
`endif
                  if (pick_d_s) begin
                     d_gnt        <= 1'b1;
                     out_mem_addr <= d_addr;
                     if (d_we) begin
                        mem_wr   <= 1'b1;
                        out_data <= d_wdata;
                        write_r  <= 1'b1;
                        state_r  <= RESP;
                     end else begin
                        mem_rd     <= 1'b1;
                        write_r    <= 1'b0;
                        wait_cnt_r <= LAT_LOAD;
                        state_r    <= RD_WAIT;
                     end
                  end else begin
                     if_gnt       <= 1'b1;
                     out_mem_addr <= if_addr;
                     mem_rd       <= 1'b1;
                     write_r      <= 1'b0;
                     wait_cnt_r   <= LAT_LOAD;
                     state_r      <= RD_WAIT;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_WAIT: begin
               if (wait_cnt_r == 3'd0) begin
                  state_r <= RESP;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 3'd1;
               end
            end
            RESP: begin
               // Memory data is valid during this cycle for reads; stores just ack.
               if (write_r) begin
                  d_rvalid <= 1'b1;
               end else if (owner_d_r) begin
                  d_rvalid <= 1'b1;
                  d_rdata  <= in_data;
               end else begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= in_data;
               end
               state_r <= IDLE;
            end
            default: begin
               state_r    <= IDLE;
               wait_cnt_r <= 3'd0;
            end
         endcase
      end
   end

endmodule
